// File: rtl/uart_cmd_scheduler_if.sv
// Bundle between command sources, the scheduler and the 12-byte UART command transmitter.
// The scheduler takes the slave modport; the requester/transmitter side takes master.
interface uart_cmd_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ-1:0][11:0][7:0]   cmd_in;
  logic [NUM_REQ-1:0]              gnt;
  logic                            tx_start;
  logic [11:0][7:0]                tx_cmd_buf;
  logic                            busy;
  logic [$clog2(NUM_REQ)-1:0]      last_src;

  modport master (
    output req, cmd_in,
    input  gnt, tx_start, tx_cmd_buf, busy, last_src
  );

  modport slave (
    input  req, cmd_in,
    output gnt, tx_start, tx_cmd_buf, busy, last_src
  );
endinterface

// File: rtl/uart_cmd_scheduler.sv
// Round-robin scheduler sharing one UART command transmitter among NUM_REQ sources; frames
// are timed by a counter. Define UART_CMD_CHECKSUM_EN to replace byte 11 with XOR of bytes 0..10.
module uart_cmd_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned FRAME_CYCLES = 132,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_cmd_scheduler_if.slave  bus
);

  localparam int unsigned SrcW   = $clog2(NUM_REQ);
  localparam int unsigned MaxCnt = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StGap} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SrcW-1:0]     last_src_q, last_src_d;
  logic [11:0][7:0]    buf_q, buf_d;
  logic                tx_start_q, tx_start_d;

  logic                found;
  logic [SrcW-1:0]     winner;
  logic [SrcW-1:0]     cand;
  logic [11:0][7:0]    sel_cmd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_src_q <= SrcW'(NUM_REQ - 1);
      buf_q      <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_src_q <= last_src_d;
      buf_q      <= buf_d;
      tx_start_q <= tx_start_d;
    end
  end

  // First requester found scanning upward from the previous winner, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = last_src_q;
    cand   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = SrcW'((32'(last_src_q) + off) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = '0;
    for (int b = 0; b < 11; b++) begin
      csum = csum ^ bus.cmd_in[winner][b];
    end
    sel_cmd     = bus.cmd_in[winner];
    sel_cmd[11] = csum;
  end
`else
  always_comb begin
    sel_cmd = bus.cmd_in[winner];
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_src_d = last_src_q;
    buf_d      = buf_q;
    tx_start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StLaunch;
          last_src_d = winner;
          buf_d      = sel_cmd;
        end
      end
      StLaunch: begin
        tx_start_d = 1'b1;
        cnt_d      = CntW'(FRAME_CYCLES - 1);
        state_d    = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            cnt_d   = CntW'(GAP_CYCLES - 1);
            state_d = StGap;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // gnt is asserted for the single LAUNCH cycle; last_src_q already holds the winner then.
  always_comb begin
    bus.gnt = '0;
    if (state_q == StLaunch) begin
      bus.gnt[last_src_q] = 1'b1;
    end
    bus.tx_start   = tx_start_q;
    bus.tx_cmd_buf = buf_q;
    bus.busy       = (state_q != StIdle);
    bus.last_src   = last_src_q;
  end

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Self-checking bench for uart_cmd_scheduler: per-cycle reference model, arbitration table,
// directed multi-cycle sequences and randomized requests.
module tb_uart_cmd_scheduler;

  localparam int N = 4;
  localparam int F = 132;
  localparam int G = 4;
  localparam int P = 2 + F + G;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_cmd_scheduler_if #(.NUM_REQ(N)) bus ();

  uart_cmd_scheduler #(
    .NUM_REQ     (N),
    .FRAME_CYCLES(F),
    .GAP_CYCLES  (G)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_gnt;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cnt = 0;

  // Model: m_t = cycles since the grant cycle (-1 when idle).
  int               m_t    = -1;
  int               m_last = N - 1;
  logic [11:0][7:0] m_buf  = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    logic found;
    int   c;
    logic [7:0] x;
    if (!rst_n) begin
      m_t = -1; m_last = N - 1; m_buf = '0;
    end else if (m_t >= 0) begin
      m_t++;
      if (m_t == P - 1) m_t = -1;
    end else if (bus.req != '0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && bus.req[c]) begin
          found = 1'b1; m_last = c;
        end
      end
      m_buf = bus.cmd_in[m_last];
`ifdef UART_CMD_CHECKSUM_EN
      x = 8'h00;
      for (int b = 0; b < 11; b++) x = x ^ m_buf[b];
      m_buf[11] = x;
`endif
      m_t = 0;
    end
  endtask

  task automatic step();
    logic [3:0] eg;
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    if (bus.tx_start) start_cnt++;
    eg = (m_t == 0) ? (4'b0001 << m_last) : 4'b0000;
    check("cycle", {bus.gnt, bus.tx_start, bus.busy, bus.last_src, bus.tx_cmd_buf},
          {eg, (m_t == 1), (m_t >= 0), 2'(m_last), m_buf});
  endtask

  task automatic wait_gnt(output int at);
    int n;
    n = 0;
    while (bus.gnt == '0 && n < 400) begin
      step(); n++;
    end
    at = cyc;
    if (bus.gnt == '0) begin
      total++; bad++;
      $display("FAIL gnt_timeout: got no gnt after %0d cycles required within 400", n);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 400) begin
      step(); n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; step();
    rst_n = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   t0, t1, n, g_at[4];
    logic [3:0] g_val[4];
    logic [7:0] x;

    tbl[0] = '{4'b0010, 4'b0010};
    tbl[1] = '{4'b1001, 4'b1000};
    tbl[2] = '{4'b0110, 4'b0010};
    tbl[3] = '{4'b0101, 4'b0100};
    tbl[4] = '{4'b0011, 4'b0001};
    tbl[5] = '{4'b1111, 4'b0010};
    tbl[6] = '{4'b0001, 4'b0001};
    tbl[7] = '{4'b1100, 4'b0100};

    rst_n = 1'b0;
    bus.req = '0;
    for (int s = 0; s < N; s++)
      for (int b = 0; b < 12; b++)
        bus.cmd_in[s][b] = (s == 1) ? 8'(b + 1) : 8'(s * 16 + b);
    @(negedge clk);
    step();
    rst_n = 1'b1;

    // Idle with no requests.
    n = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.gnt != 0 || bus.tx_start || bus.busy || bus.last_src != 2'd3) n++;
    end
    check("idle_quiet", 32'(n), 32'd0);

    // Arbitration table.
    for (int i = 0; i < 8; i++) begin
      bus.req = tbl[i].req;
      wait_gnt(t0);
      check("tbl_gnt", bus.gnt, tbl[i].exp_gnt);
      bus.req = '0;
      step();
      check("tbl_start", bus.tx_start, 1'b1);
      for (int s = 0; s < N; s++)
        if (tbl[i].exp_gnt[s]) check("tbl_byte0", bus.tx_cmd_buf[0], bus.cmd_in[s][0]);
      if (i == 0) begin
        check("src1_byte0", bus.tx_cmd_buf[0], 8'h01);
`ifndef UART_CMD_CHECKSUM_EN
        check("src1_byte11", bus.tx_cmd_buf[11], 8'h0C);
`endif
      end
      wait_idle(n);
      check("busy_len", 32'(n + 1), 32'(P - 1));
    end

    // Four requesters held: order 0,1,2,3 at full frame period.
    do_reset();
    start_cnt = 0;
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g_at[i]);
      g_val[i] = bus.gnt;
      if (i < 3) step();
    end
    bus.req = '0;
    step();
    for (int i = 0; i < 4; i++) begin
      check("rr_order", g_val[i], 4'b0001 << i);
      if (i > 0) check("rr_spacing", 32'(g_at[i] - g_at[i-1]), 32'(P));
    end
    check("start_count", 32'(start_cnt), 32'd4);
    wait_idle(n);

    // Request arriving mid-frame is deferred to the next idle cycle.
    bus.req = 4'b0001;
    wait_gnt(t0);
    check("mid_first", bus.gnt, 4'b0001);
    bus.req = '0;
    for (int i = 0; i < 30; i++) step();
    bus.req = 4'b0100;
    wait_gnt(t1);
    check("mid_gnt", bus.gnt, 4'b0100);
    check("mid_spacing", 32'(t1 - t0), 32'(P));
    bus.req = '0;
    wait_idle(n);

    // Reset in the middle of a frame with source 0 holding its request.
    bus.req = 4'b0001;
    wait_gnt(t0);
    for (int i = 0; i < 72; i++) step();
    check("pre_rst_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    step();
    check("rst_clear", {bus.gnt, bus.tx_start, bus.busy, bus.last_src, bus.tx_cmd_buf},
          {4'b0000, 1'b0, 1'b0, 2'd3, 96'h0});
    rst_n = 1'b1;
    step();
    check("rst_regrant", bus.gnt, 4'b0001);
    bus.req = '0;
    wait_idle(n);

    // Byte 11 handling: checksum when enabled, pass-through otherwise.
    for (int b = 0; b < 11; b++) bus.cmd_in[2][b] = 8'(b + 1);
    bus.cmd_in[2][11] = 8'hAA;
`ifdef UART_CMD_CHECKSUM_EN
    x = 8'h00;
    for (int b = 0; b < 11; b++) x = x ^ 8'(b + 1);
`else
    x = 8'hAA;
`endif
    bus.req = 4'b0100;
    wait_gnt(t0);
    step();
    check("byte11", bus.tx_cmd_buf[11], x);
    check("byte10", bus.tx_cmd_buf[10], 8'h0B);
    bus.req = '0;
    wait_idle(n);

    // Randomized requests, commands and occasional resets against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.req = 4'($urandom_range(0, 15));
        for (int s = 0; s < N; s++)
          for (int b = 0; b < 12; b++)
            if (!bus.req[s]) bus.cmd_in[s][b] = 8'($urandom);
      end
      rst_n = ($urandom_range(0, 599) != 0);
      step();
      if (bus.gnt != '0) bus.req = bus.req & ~bus.gnt;
    end
    rst_n = 1'b1;
    bus.req = '0;
    wait_idle(n);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
